// File: rtl/chien_search.sv
// Serial Chien search for the RS(255,249) decoder: evaluates sigma(x) at alpha^-j
// for j = 0..N-1, strobes each root position, then reports root count and failure.
module chien_search #(
  parameter int N = 255,
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         signal,
  input  logic [M-1:0] s0,
  input  logic [M-1:0] s1,
  input  logic [M-1:0] s2,
  input  logic [M-1:0] s3,
  output logic         ready,
  output logic         loc_valid,
  output logic [M-1:0] loc,
  output logic         done,
  output logic [1:0]   err_count,
  output logic         fail
);

  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

  state_t       state;
  logic [M-1:0] t0, t1, t2, t3;
  logic [7:0]   idx;
  logic [1:0]   count;
  logic [1:0]   deg;
  logic         s0zero;

  logic [M-1:0] sum, n1, n2, n3;
  logic [1:0]   deg_in;

  // GF(2^8) multiply mod 0x11D; used with constant operands it folds to XOR trees.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] p;
    logic [M-1:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < M; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[M-2:0], 1'b0} ^ (x[M-1] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  assign sum = t0 ^ t1 ^ t2 ^ t3;
  assign n1  = gf_mul(t1, 8'h8E);
  assign n2  = gf_mul(t2, 8'h47);
  assign n3  = gf_mul(t3, 8'hAD);

  always_comb begin
    deg_in = 2'd0;
    if (s3 != '0)      deg_in = 2'd3;
    else if (s2 != '0) deg_in = 2'd2;
    else if (s1 != '0) deg_in = 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b1;
      loc_valid <= 1'b0;
      loc       <= '0;
      done      <= 1'b0;
      err_count <= '0;
      fail      <= 1'b0;
      t0        <= '0;
      t1        <= '0;
      t2        <= '0;
      t3        <= '0;
      idx       <= '0;
      count     <= '0;
      deg       <= '0;
      s0zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (signal) begin
            t0        <= s0;
            t1        <= s1;
            t2        <= s2;
            t3        <= s3;
            idx       <= '0;
            count     <= '0;
            deg       <= deg_in;
            s0zero    <= (s0 == '0);
            ready     <= 1'b0;
            err_count <= '0;
            fail      <= 1'b0;
            state     <= (s0 == '0) ? FIN : SCAN;
          end
        end
        SCAN: begin
          if (sum == '0) begin
            loc_valid <= 1'b1;
            loc       <= idx;
            if (count != 2'd3) count <= count + 2'd1;
          end else begin
            loc_valid <= 1'b0;
          end
          t1 <= n1;
          t2 <= n2;
          t3 <= n3;
          if (idx == 8'(N - 1)) state <= FIN;
          else                  idx   <= idx + 8'd1;
        end
        FIN: begin
          loc_valid <= 1'b0;
          done      <= 1'b1;
          err_count <= count;
          fail      <= (count != deg) || s0zero;
          ready     <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chien_search.sv
// Bench for chien_search: directed and randomized sigma polynomials checked against
// a direct polynomial-evaluation model over GF(2^8).
module tb_chien_search;

  localparam int N = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       signal = 1'b0;
  logic [7:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0;
  logic       ready, loc_valid, done, fail;
  logic [7:0] loc;
  logic [1:0] err_count;

  int vectors = 0;
  int miscompares = 0;

  chien_search #(.N(N), .M(8)) dut (
    .clk(clk), .rst(rst), .signal(signal),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .ready(ready), .loc_valid(loc_valid), .loc(loc),
    .done(done), .err_count(err_count), .fail(fail)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11D << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] apow(input int e);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < (e % 255); i++) r = gmul(r, 8'h02);
    return r;
  endfunction

  // sigma evaluated at alpha^-j, straight from the polynomial definition
  function automatic logic [7:0] eval_at(input logic [7:0] a0, a1, a2, a3, input int j);
    logic [7:0] x  = apow(255 - j);
    logic [7:0] x2 = gmul(x, x);
    return a0 ^ gmul(a1, x) ^ gmul(a2, x2) ^ gmul(a3, gmul(x2, x));
  endfunction

  // c * prod (1 + alpha^r x) over the first nr roots; returns {p3,p2,p1,p0}
  function automatic logic [31:0] poly_from_roots(input logic [7:0] c, input int nr,
                                                  input int ra, input int rb, input int rc);
    logic [7:0] p[4];
    int rs[3];
    rs[0] = ra; rs[1] = rb; rs[2] = rc;
    p[0] = c; p[1] = '0; p[2] = '0; p[3] = '0;
    for (int k = 0; k < nr; k++) begin
      logic [7:0] a = apow(rs[k]);
      for (int i = 3; i >= 1; i--) p[i] = p[i] ^ gmul(a, p[i-1]);
    end
    return {p[3], p[2], p[1], p[0]};
  endfunction

  // Start a search at the current negedge; returns at the negedge after the start edge.
  task automatic launch(input logic [7:0] a0, a1, a2, a3);
    signal = 1'b1; s0 = a0; s1 = a1; s2 = a2; s3 = a3;
    @(negedge clk);
    signal = 1'b0;
    vectors++;
    if (ready !== 1'b0 || err_count !== 2'd0 || fail !== 1'b0) begin
      miscompares++;
      $display("FAIL launch_state: ready=%b err_count=%0d fail=%b, required ready=0 err_count=0 fail=0",
               ready, err_count, fail);
    end
  endtask

  // Follow a running search to completion and compare against the model.
  task automatic collect(input logic [7:0] a0, a1, a2, a3, input bit inject);
    int exp_locs[$];
    int deg, got, exp_edge;
    logic [1:0] exp_cnt;
    logic exp_fail;
    bit seen_done = 0;
    got = 0;
    deg = (a3 != 0) ? 3 : (a2 != 0) ? 2 : (a1 != 0) ? 1 : 0;
    if (a0 != 0)
      for (int j = 0; j < N; j++) if (eval_at(a0, a1, a2, a3, j) == 8'h00) exp_locs.push_back(j);
    exp_cnt  = (exp_locs.size() > 3) ? 2'd3 : 2'(exp_locs.size());
    exp_fail = (a0 == 0) || (int'(exp_cnt) != deg);
    exp_edge = (a0 == 0) ? 1 : N + 1;
    for (int e = 1; e <= N + 40 && !seen_done; e++) begin
      @(negedge clk);
      if (loc_valid) begin
        vectors++;
        if (got >= exp_locs.size()) begin
          miscompares++;
          $display("FAIL extra_loc: loc=%0d after edge %0d, no further root expected", loc, e);
        end else if (loc !== 8'(exp_locs[got]) || loc !== 8'(e - 1)) begin
          miscompares++;
          $display("FAIL loc_value: loc=%0d after edge %0d, required %0d", loc, e, exp_locs[got]);
        end
        got++;
      end
      if (done) begin
        seen_done = 1;
        vectors++;
        if (e != exp_edge || err_count !== exp_cnt || fail !== exp_fail || ready !== 1'b1) begin
          miscompares++;
          $display("FAIL done_result: edge=%0d err_count=%0d fail=%b ready=%b, required edge=%0d err_count=%0d fail=%b ready=1",
                   e, err_count, fail, ready, exp_edge, exp_cnt, exp_fail);
        end
      end
      if (inject && e == 40) begin
        signal = 1'b1; s0 = 8'($urandom_range(1, 255)); s1 = 8'($urandom);
        s2 = 8'($urandom); s3 = 8'($urandom);
      end else if (inject && e == 41) begin
        signal = 1'b0;
      end
    end
    vectors++;
    if (!seen_done || got != exp_locs.size()) begin
      miscompares++;
      $display("FAIL search_summary: done_seen=%0d locs=%0d, required done_seen=1 locs=%0d",
               seen_done, got, exp_locs.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (ready !== 1'b1 || loc_valid !== 1'b0 || loc !== 8'h00 || done !== 1'b0 ||
        err_count !== 2'd0 || fail !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b loc_valid=%b loc=%h done=%b err_count=%0d fail=%b",
               ready, loc_valid, loc, done, err_count, fail);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run(input logic [7:0] a0, a1, a2, a3);
    launch(a0, a1, a2, a3);
    collect(a0, a1, a2, a3, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_directed;
    run(8'h01, 8'h20, 8'h00, 8'h00);  // single error at 5
    run(8'h01, 8'h03, 8'h02, 8'h00);  // errors at 0 and 1
    run(8'h01, 8'h00, 8'h00, 8'h00);  // no error
    run(8'h01, 8'h00, 8'h01, 8'h00);  // repeated root at 0
    run(8'h00, 8'h05, 8'h00, 8'h00);  // invalid s0
    run(8'h01, 8'h00, 8'h00, 8'h80);  // deg 3 polynomial, checked by the model
  endtask

  task automatic test_signal_midscan;
    logic [31:0] p = poly_from_roots(8'h01, 3, 10, 120, 254);
    launch(p[7:0], p[15:8], p[23:16], p[31:24]);
    collect(p[7:0], p[15:8], p[23:16], p[31:24], 1'b1);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] p = poly_from_roots(8'h37, 2, 0, 254, 0);
    logic [31:0] q = poly_from_roots(8'h01, 1, 77, 0, 0);
    launch(p[7:0], p[15:8], p[23:16], p[31:24]);
    collect(p[7:0], p[15:8], p[23:16], p[31:24], 1'b0);
    launch(q[7:0], q[15:8], q[23:16], q[31:24]);  // issued in the done cycle
    collect(q[7:0], q[15:8], q[23:16], q[31:24], 1'b0);
    @(negedge clk);
  endtask

  task automatic test_reset_midscan;
    logic [31:0] p = poly_from_roots(8'h01, 2, 50, 150, 0);
    bit stray = 0;
    launch(p[7:0], p[15:8], p[23:16], p[31:24]);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (ready !== 1'b1 || loc_valid !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midscan: ready=%b loc_valid=%b done=%b, required 1/0/0", ready, loc_valid, done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < N + 20; e++) begin
      @(negedge clk);
      if (done || loc_valid || !ready) stray = 1;
    end
    vectors++;
    if (stray) begin
      miscompares++;
      $display("FAIL reset_abort: activity after reset, done=%b loc_valid=%b ready=%b", done, loc_valid, ready);
    end
    run(p[7:0], p[15:8], p[23:16], p[31:24]);
  endtask

  task automatic test_random;
    for (int n = 0; n < 10; n++) begin
      logic [31:0] p;
      if (n % 4 == 3)
        p = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(1, 255))};
      else
        p = poly_from_roots(8'($urandom_range(1, 255)), $urandom_range(0, 3),
                            $urandom_range(0, 254), $urandom_range(0, 254), $urandom_range(0, 254));
      run(p[7:0], p[15:8], p[23:16], p[31:24]);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_signal_midscan;
    test_back_to_back;
    test_reset_midscan;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
